mnist_pattern_sequencer: RTL and testbench

MNIST_PATTERN_SEQUENCER -- requirements
Module: mnist_pattern_sequencer

---
 rtl/mnist_pattern_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_mnist_pattern_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mnist_pattern_sequencer.sv
// Streams stored image frames byte-by-byte to a classifier core, latches the
// core's answer once per frame and steps through the stored patterns either
// on a dwell timer or on a debounced push-button.
`timescale 1ns/1ps

module mnist_pattern_sequencer #(
  parameter int unsigned NUM_PATTERNS    = 4,
  parameter int unsigned FRAME_BYTES     = 32,
  parameter int unsigned BYTE_W          = 8,
  parameter int unsigned RESULT_W        = 4,
  parameter int unsigned LATCH_OFFSET    = 3,
  parameter int unsigned DWELL_CYCLES    = 12000000,
  parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           mode_auto,
  input  logic                                           btn_next,
  input  logic                                           pat_wr_en,
  input  logic [$clog2(NUM_PATTERNS*FRAME_BYTES)-1:0]    pat_wr_addr,
  input  logic [BYTE_W-1:0]                              pat_wr_data,
  output logic [BYTE_W-1:0]                              core_in,
  input  logic [RESULT_W-1:0]                            core_result,
  output logic                                           frame_start,
  output logic [$clog2(NUM_PATTERNS)-1:0]                pattern_sel,
  output logic [RESULT_W-1:0]                            result_out,
  output logic                                           result_valid
);

  localparam int unsigned DEPTH   = NUM_PATTERNS * FRAME_BYTES;
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned SEL_W   = $clog2(NUM_PATTERNS);
  localparam int unsigned IDX_W   = $clog2(FRAME_BYTES);
  localparam int unsigned DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(FRAME_BYTES - 1);
  localparam logic [IDX_W-1:0]   LATCH_IDX  = IDX_W'(LATCH_OFFSET);
  localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ADV_IDLE,
    ADV_PENDING
  } adv_state_t;

  logic [BYTE_W-1:0]  mem [DEPTH];
  logic [IDX_W-1:0]   idx;
  logic [ADDR_W-1:0]  rd_addr;
  logic               wrap;

  logic               sync1;
  logic               sync2;
  logic               deb_state;
  logic [DEB_W-1:0]   deb_cnt;
  logic               deb_rise;

  logic               mode_prev;
  logic               mode_change;
  logic [DWELL_W-1:0] dwell;
  logic               dwell_tc;
  logic               new_evt;

  adv_state_t         adv_state;
  adv_state_t         adv_next;
  logic               advance;

  assign wrap        = (idx == IDX_LAST);
  assign rd_addr     = ADDR_W'(32'(pattern_sel) * FRAME_BYTES + 32'(idx));
  assign mode_change = (mode_auto != mode_prev);
  assign dwell_tc    = (dwell == DWELL_LAST);
  assign deb_rise    = sync2 && !deb_state && (deb_cnt == DEB_LAST);
  assign new_evt     = mode_auto ? dwell_tc : deb_rise;

  // Pattern memory: not reset, and writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && pat_wr_en) begin
      mem[pat_wr_addr] <= pat_wr_data;
    end
  end

  // Button synchroniser and debouncer; the count restarts whenever the
  // synchronised level matches the accepted level again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      deb_cnt   <= '0;
      deb_state <= 1'b0;
    end else begin
      sync1 <= btn_next;
      sync2 <= sync1;
      if (sync2 == deb_state) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        deb_state <= sync2;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end
  end

  // Dwell timer: runs only in auto mode and restarts on every mode change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_prev <= mode_auto;
      dwell     <= '0;
    end else begin
      mode_prev <= mode_auto;
      if (mode_change || !mode_auto || dwell_tc) begin
        dwell <= '0;
      end else begin
        dwell <= dwell + DWELL_W'(1);
      end
    end
  end

  // Advance-request state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      adv_state <= ADV_IDLE;
    end else begin
      adv_state <= adv_next;
    end
  end

  // Advance-request next state: a pending request is consumed only at the
  // frame boundary; a request arriving on that same edge stays pending.
  always_comb begin
    adv_next = adv_state;
    advance  = 1'b0;
    if (mode_change) begin
      adv_next = ADV_IDLE;
    end else begin
      if (wrap && (adv_state == ADV_PENDING)) begin
        advance = 1'b1;
      end
      if (new_evt) begin
        adv_next = ADV_PENDING;
      end else if (advance) begin
        adv_next = ADV_IDLE;
      end
    end
  end

  // Free-running byte index and active pattern number.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      pattern_sel <= '0;
    end else begin
      idx <= wrap ? '0 : idx + IDX_W'(1);
      if (advance) begin
        pattern_sel <= (pattern_sel == SEL_LAST) ? '0 : pattern_sel + SEL_W'(1);
      end
    end
  end

  // Registered byte stream, frame marker and once-per-frame result latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      core_in      <= '0;
      frame_start  <= 1'b0;
      result_out   <= '0;
      result_valid <= 1'b0;
    end else begin
      core_in     <= mem[rd_addr];
      frame_start <= (idx == '0);
      if (idx == LATCH_IDX) begin
        result_out   <= core_result;
        result_valid <= 1'b1;
      end else begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mnist_pattern_sequencer.sv
// Scoreboard bench: the stimulus process queues the expected contents of every
// frame; a monitor collects each frame as the DUT streams it and compares.
`timescale 1ns/1ps

module tb_mnist_pattern_sequencer;

  localparam int unsigned NP = 2;
  localparam int unsigned FB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode_auto;
  logic       btn_next;
  logic       pat_wr_en;
  logic [2:0] pat_wr_addr;
  logic [7:0] pat_wr_data;
  logic [7:0] core_in;
  logic [3:0] core_result;
  logic       frame_start;
  logic       pattern_sel;
  logic [3:0] result_out;
  logic       result_valid;

  always #5 clk = ~clk;

  mnist_pattern_sequencer #(
    .NUM_PATTERNS(NP),
    .FRAME_BYTES(FB),
    .BYTE_W(8),
    .RESULT_W(4),
    .LATCH_OFFSET(3),
    .DWELL_CYCLES(10),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_auto(mode_auto),
    .btn_next(btn_next),
    .pat_wr_en(pat_wr_en),
    .pat_wr_addr(pat_wr_addr),
    .pat_wr_data(pat_wr_data),
    .core_in(core_in),
    .core_result(core_result),
    .frame_start(frame_start),
    .pattern_sel(pattern_sel),
    .result_out(result_out),
    .result_valid(result_valid)
  );

  typedef struct packed {
    logic [31:0] bytes;
    logic        sel;
  } frame_t;

  localparam logic [31:0] W0  = 32'h10111213;
  localparam logic [31:0] W1  = 32'h14151617;
  localparam logic [31:0] W1A = 32'hAA151617;

  frame_t      exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          edge_n = 0;
  int          base = 0;
  logic        mon_en = 1'b0;

  logic [31:0] m_word;
  logic [3:0]  m_fs;
  logic [3:0]  m_rv;
  logic        m_sel;
  logic [3:0]  m_res;
  frame_t      m_exp;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_to(input int t);
    while (edge_n < base + t) tick(1);
  endtask

  task automatic push(input logic [31:0] w, input logic s, input int n);
    repeat (n) exp_q.push_back('{bytes: w, sel: s});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_core_in"},      32'(core_in),      32'h0);
    check({tag, "_frame_start"},  32'(frame_start),  32'h0);
    check({tag, "_pattern_sel"},  32'(pattern_sel),  32'h0);
    check({tag, "_result_out"},   32'(result_out),   32'h0);
    check({tag, "_result_valid"}, 32'(result_valid), 32'h0);
  endtask

  // Monitor: one frame window = the frame_start cycle plus three more bytes.
  always begin
    @(negedge clk);
    if (mon_en && frame_start === 1'b1) begin
      m_sel  = pattern_sel;
      m_word = '0;
      m_fs   = '0;
      m_rv   = '0;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        m_word = {m_word[23:0], core_in};
        m_fs   = {m_fs[2:0], frame_start};
        m_rv   = {m_rv[2:0], result_valid};
      end
      m_res = result_out;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got bytes 0x%0h sel %0d, expected no frame", m_word, m_sel);
      end else begin
        m_exp = exp_q.pop_front();
        check("frame_bytes",  m_word,      m_exp.bytes);
        check("frame_sel",    32'(m_sel),  32'(m_exp.sel));
        check("frame_start_pattern", 32'(m_fs), 32'h8);
        check("result_valid_pattern", 32'(m_rv), 32'h1);
        check("result_out",   32'(m_res),  32'h7);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    mode_auto   = 1'b0;
    btn_next    = 1'b0;
    pat_wr_en   = 1'b0;
    pat_wr_addr = '0;
    pat_wr_data = '0;
    core_result = 4'd7;
    tick(3);
    check_reset("rst0");

    // Load both patterns with reset released.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pat_wr_en   = 1'b1;
      pat_wr_addr = 3'(i);
      pat_wr_data = 8'(32'h10 + i);
      tick(1);
    end
    pat_wr_en = 1'b0;
    tick(2);

    // Write attempted during reset must not land.
    rst_n       = 1'b0;
    pat_wr_en   = 1'b1;
    pat_wr_addr = 3'd0;
    pat_wr_data = 8'hEE;
    tick(2);
    pat_wr_en = 1'b0;
    check_reset("rst1");

    // Main run; times below are edges after this release.
    base   = edge_n;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push(W0,  1'b0, 6);   // frames 0-5; dwell terminal count at edge 20 coincides with a wrap
    push(W1,  1'b1, 2);   // frames 6-7
    push(W0,  1'b0, 3);   // frames 8-10
    push(W1,  1'b1, 3);   // frames 11-13; pending cleared by mode switch before edge 52
    push(W1A, 1'b1, 4);   // frames 14-17; mem[4] rewritten at edge 53
    push(W0,  1'b0, 4);   // frames 18-21; held button advances at edge 72
    push(W1A, 1'b1, 2);   // frames 22-23

    wait_to(9);  mode_auto = 1'b1;
    wait_to(50); mode_auto = 1'b0;
    wait_to(52); pat_wr_en = 1'b1; pat_wr_addr = 3'd4; pat_wr_data = 8'hAA;
    wait_to(53); pat_wr_en = 1'b0;
    wait_to(58); btn_next = 1'b1;   // two-cycle glitch, rejected
    wait_to(60); btn_next = 1'b0;
    wait_to(64); btn_next = 1'b1;   // eight-cycle press, one advance
    wait_to(72); btn_next = 1'b0;
    wait_to(80); btn_next = 1'b1;
    wait_to(84); btn_next = 1'b0;
    wait_to(92); btn_next = 1'b1;   // pending at edge 97, never consumed
    wait_to(96); btn_next = 1'b0; mon_en = 1'b0;
    wait_to(98); rst_n = 1'b0;
    wait_to(99); check_reset("rst2");
    check("pending_before_reset_sel", 32'(pattern_sel), 32'h0);

    wait_to(100);
    base   = edge_n;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    push(W0, 1'b0, 3);
    wait_to(12); mon_en = 1'b0;
    tick(6);
    check("leftover_frames", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
